// File: rtl/monster_shot_scheduler.sv
// monster_shot_scheduler: once per frame, probe forward from a random column for a live
// monster, allocate the lowest free shot slot and pulse fire for one cycle.
module monster_shot_scheduler #(
    parameter int COL_BITS        = 6,
    parameter int MAX_COL         = 62,
    parameter int NUM_SLOTS       = 4,
    parameter int SLOT_BITS       = 2,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int MAX_PROBE       = 8
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 enable,
    input  logic [COL_BITS-1:0]  rand_col,
    input  logic [MAX_COL:0]     col_alive,
    input  logic [NUM_SLOTS-1:0] slot_done,
    output logic                 fire,
    output logic [COL_BITS-1:0]  fire_col,
    output logic [SLOT_BITS-1:0] fire_slot,
    output logic [NUM_SLOTS-1:0] slots_busy,
    output logic                 sched_busy
);
    localparam int CNT_W = $clog2(MAX_PROBE + 1);
    localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [COL_BITS-1:0] MAX_C   = COL_BITS'(MAX_COL);
    localparam logic [CNT_W-1:0]    MAX_P   = CNT_W'(MAX_PROBE);
    localparam logic [CD_W-1:0]     CD_INIT = CD_W'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {IDLE, SAMPLE, PROBE} state_t;

    state_t                 state_q;
    logic                   sof_q;
    logic [COL_BITS-1:0]    probe_col_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CD_W-1:0]        cd_q;
    logic                   fire_q;
    logic [COL_BITS-1:0]    fire_col_q;
    logic [SLOT_BITS-1:0]   fire_slot_q;
    logic [NUM_SLOTS-1:0]   slots_busy_q, slots_busy_d;
    logic [SLOT_BITS-1:0]   free_slot;
    logic                   sof_rise, any_free, hit, fire_now;

    assign sof_rise = startOfFrame & ~sof_q;
    assign any_free = ~&slots_busy_q;
    assign hit      = col_alive[probe_col_q] & any_free;
    assign fire_now = (state_q == PROBE) & enable & hit;

    always_comb begin
        free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (!slots_busy_q[i]) free_slot = SLOT_BITS'(i);
    end

    // allocation looks only at the pre-edge busy vector, so a slot freed this edge waits a cycle
    assign slots_busy_d = (slots_busy_q & ~slot_done) |
                          (fire_now ? NUM_SLOTS'(1) << free_slot : '0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            sof_q        <= 1'b0;
            probe_col_q  <= '0;
            cnt_q        <= '0;
            cd_q         <= '0;
            fire_q       <= 1'b0;
            fire_col_q   <= '0;
            fire_slot_q  <= '0;
            slots_busy_q <= '0;
        end else begin
            sof_q        <= startOfFrame;
            fire_q       <= 1'b0;
            slots_busy_q <= slots_busy_d;
            if (!enable) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (sof_rise) begin
                            if (cd_q != '0) cd_q <= cd_q - 1'b1;
                            else if (any_free) state_q <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        probe_col_q <= (rand_col > MAX_C) ? '0 : rand_col;
                        cnt_q       <= CNT_W'(1);
                        state_q     <= PROBE;
                    end
                    PROBE: begin
                        if (hit) begin
                            fire_q      <= 1'b1;
                            fire_col_q  <= probe_col_q;
                            fire_slot_q <= free_slot;
                            cd_q        <= CD_INIT;
                            state_q     <= IDLE;
                        end else if (cnt_q == MAX_P) begin
                            state_q <= IDLE;
                        end else begin
                            probe_col_q <= (probe_col_q == MAX_C) ? '0 : probe_col_q + 1'b1;
                            cnt_q       <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign fire       = fire_q;
    assign fire_col   = fire_col_q;
    assign fire_slot  = fire_slot_q;
    assign slots_busy = slots_busy_q;
    assign sched_busy = (state_q != IDLE);
endmodule

// File: tb/tb_monster_shot_scheduler.sv
// tb_monster_shot_scheduler: two instances (cooldown 0 and 2) checked every cycle against a
// frame-level reference model, plus vector table and directed corner-case sequences.
module tb_monster_shot_scheduler;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        sof = 1'b0;
    logic        en = 1'b1;
    logic [5:0]  rcol = '0;
    logic [62:0] alive = '0;
    logic [3:0]  sdone = '0;
    logic        f0, f1, bz0, bz1;
    logic [5:0]  fc0, fc1;
    logic [1:0]  fs0, fs1;
    logic [3:0]  sb0, sb1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    monster_shot_scheduler #(.COOLDOWN_FRAMES(0)) u0 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en), .rand_col(rcol),
        .col_alive(alive), .slot_done(sdone), .fire(f0), .fire_col(fc0), .fire_slot(fs0),
        .slots_busy(sb0), .sched_busy(bz0));
    monster_shot_scheduler #(.COOLDOWN_FRAMES(2)) u1 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en), .rand_col(rcol),
        .col_alive(alive), .slot_done(sdone), .fire(f1), .fire_col(fc1), .fire_slot(fs1),
        .slots_busy(sb1), .sched_busy(bz1));

    // reference model: a frame is "in flight" from its SOF edge t0; probe k happens at edge t0+2+k
    bit         m_act[2];
    int         m_t0[2], m_st[2], m_cd[2], m_fcol[2], m_fslot[2];
    logic [3:0] m_busy[2];
    bit         m_fire[2];
    bit         m_psof;

    task automatic step(input int i, input bit rise);
        logic [3:0] nb;
        int k, col, cdv;
        cdv = (i == 0) ? 0 : 2;
        if (!resetN) begin
            m_act[i] = 0; m_cd[i] = 0; m_busy[i] = '0; m_fire[i] = 0; m_fcol[i] = 0; m_fslot[i] = 0;
        end else begin
            nb = m_busy[i] & ~sdone;
            m_fire[i] = 0;
            if (m_act[i]) begin
                if (!en) m_act[i] = 0;
                else if (cyc == m_t0[i] + 1) m_st[i] = (rcol > 62) ? 0 : int'(rcol);
                else begin
                    k = cyc - m_t0[i] - 2;
                    col = (m_st[i] + k) % 63;
                    if (alive[col] && m_busy[i] != 4'hF) begin
                        m_fire[i] = 1;
                        m_fcol[i] = col;
                        for (int s = 3; s >= 0; s--) if (!m_busy[i][s]) m_fslot[i] = s;
                        nb[m_fslot[i]] = 1'b1;
                        m_cd[i] = cdv;
                        m_act[i] = 0;
                    end else if (k == 7) m_act[i] = 0;
                end
            end else if (rise && en) begin
                if (m_cd[i] > 0) m_cd[i]--;
                else if (m_busy[i] != 4'hF) begin
                    m_act[i] = 1;
                    m_t0[i] = cyc;
                end
            end
            m_busy[i] = nb;
        end
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d want %0d", nm, cyc, got, want);
        end
    endtask

    task automatic compare_all();
        chk("u0_fire", int'(f0), int'(m_fire[0]));
        chk("u0_fire_col", int'(fc0), m_fcol[0]);
        chk("u0_fire_slot", int'(fs0), m_fslot[0]);
        chk("u0_slots_busy", int'(sb0), int'(m_busy[0]));
        chk("u0_sched_busy", int'(bz0), int'(m_act[0]));
        chk("u1_fire", int'(f1), int'(m_fire[1]));
        chk("u1_fire_col", int'(fc1), m_fcol[1]);
        chk("u1_fire_slot", int'(fs1), m_fslot[1]);
        chk("u1_slots_busy", int'(sb1), int'(m_busy[1]));
        chk("u1_sched_busy", int'(bz1), int'(m_act[1]));
    endtask

    task automatic tick();
        bit rise;
        @(posedge clk);
        cyc++;
        rise = sof && !m_psof;
        step(0, rise);
        step(1, rise);
        m_psof = resetN ? sof : 1'b0;
        @(negedge clk);
        compare_all();
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0; sof = 1'b0; en = 1'b1; sdone = '0;
        tick(); tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic run_frame(output bit fired0, output int slot0, output bit fired1);
        fired0 = 0; slot0 = -1; fired1 = 0;
        sof = 1'b1;
        for (int j = 0; j < 12; j++) begin
            tick();
            sof = 1'b0;
            if (f0) begin fired0 = 1; slot0 = int'(fs0); end
            if (f1) fired1 = 1;
        end
    endtask

    typedef struct {
        logic [5:0]  rc;
        logic [62:0] al;
        int          dly;
        int          col;
    } vec_t;

    vec_t vt[8];

    initial begin
        bit fr0, fr1;
        bit u1_hist[4];
        int sl, fired, gcol, len;
        logic [62:0] one;
        one = 63'd1;
        vt[0] = '{6'd17, {63{1'b1}}, 2, 17};
        vt[1] = '{6'd61, one << 2, 6, 2};
        vt[2] = '{6'd0, '0, -1, 0};
        vt[3] = '{6'd63, '0, -1, 0};
        vt[4] = '{6'd63, one, 2, 0};
        vt[5] = '{6'd60, one << 3, 8, 3};
        vt[6] = '{6'd10, one << 18, -1, 0};
        vt[7] = '{6'd10, one << 17, 9, 17};

        do_reset();
        chk("reset_fire", int'(f0), 0);
        chk("reset_busy", int'(sb0), 0);
        chk("reset_sched", int'(bz0), 0);

        foreach (vt[v]) begin
            do_reset();
            rcol = vt[v].rc; alive = vt[v].al; sof = 1'b1;
            fired = -1; gcol = -1;
            for (int j = 1; j <= 14; j++) begin
                tick();
                sof = 1'b0;
                if (f0 && fired < 0) begin fired = j - 1; gcol = int'(fc0); end
            end
            chk("vec_delay", fired, vt[v].dly);
            if (vt[v].dly >= 0) begin
                chk("vec_col", gcol, vt[v].col);
                chk("vec_slots", int'(sb0), 1);
            end
            chk("vec_idle", int'(bz0), 0);
        end

        // slots fill 0..3, fifth frame starved, freed slot 2 is reused; u1 shows cooldown 2
        do_reset();
        alive = {63{1'b1}}; rcol = 6'd17;
        for (int n = 0; n < 4; n++) begin
            run_frame(fr0, sl, fr1);
            chk("fill_fire", int'(fr0), 1);
            chk("fill_slot", sl, n);
            u1_hist[n] = fr1;
        end
        chk("cd_frame_n", int'(u1_hist[0]), 1);
        chk("cd_frame_n1", int'(u1_hist[1]), 0);
        chk("cd_frame_n2", int'(u1_hist[2]), 0);
        chk("cd_frame_n3", int'(u1_hist[3]), 1);
        run_frame(fr0, sl, fr1);
        chk("full_nofire", int'(fr0), 0);
        sdone = 4'b0100;
        tick();
        sdone = '0;
        chk("done_clear", int'(sb0), 4'b1011);
        run_frame(fr0, sl, fr1);
        chk("reuse_fire", int'(fr0), 1);
        chk("reuse_slot", sl, 2);

        // enable dropped mid-probe aborts without firing
        do_reset();
        alive = one << 5; rcol = 6'd0; sof = 1'b1;
        tick(); sof = 1'b0; tick(); tick();
        chk("abort_probing", int'(bz0), 1);
        en = 1'b0;
        tick();
        chk("abort_idle", int'(bz0), 0);
        en = 1'b1;
        fired = 0;
        for (int j = 0; j < 8; j++) begin tick(); if (f0) fired = 1; end
        chk("abort_nofire", fired, 0);

        // asynchronous reset in the middle of a probe
        do_reset();
        alive = {63{1'b1}}; rcol = 6'd40;
        run_frame(fr0, sl, fr1);
        chk("pre_col", int'(fc0), 40);
        alive = '0; sof = 1'b1;
        tick(); sof = 1'b0; tick(); tick(); tick();
        chk("pre_busy", int'(sb0), 1);
        chk("pre_sched", int'(bz0), 1);
        resetN = 1'b0;
        #1;
        chk("arst_fire", int'(f0), 0);
        chk("arst_col", int'(fc0), 0);
        chk("arst_slot", int'(fs0), 0);
        chk("arst_busy", int'(sb0), 0);
        chk("arst_sched", int'(bz0), 0);
        tick();
        resetN = 1'b1;
        tick();

        // randomized frames, model compared every cycle
        for (int n = 0; n < 400; n++) begin
            rcol = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 3))
                0: alive = '0;
                1: alive = {63{1'b1}};
                default: alive = 63'({$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()});
            endcase
            len = $urandom_range(2, 13);
            sof = 1'b1;
            for (int t = 0; t < len; t++) begin
                sdone = ($urandom_range(0, 5) == 0) ? 4'($urandom()) : 4'b0;
                en = ($urandom_range(0, 40) != 0);
                tick();
                sof = 1'b0;
            end
            sdone = '0; en = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
